temp_uart_fmt: RTL and testbench

TEMP_UART_FMT -- requirements
Module: temp_uart_fmt

---
 rtl/temp_uart_fmt_if.sv | 23 ++
 rtl/temp_uart_fmt.sv | 117 +++++++++++
 tb/tb_temp_uart_fmt.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/temp_uart_fmt_if.sv
// Handshake bundle between the temperature source / UART transmitter and the ASCII formatter.
// The formatter connects through the slave modport; the source/sink side uses master.
interface temp_uart_fmt_if #(
   parameter int DATA_W = 8,
   parameter int TEMP_W = 16
) ();
   logic [TEMP_W-1:0] temp_in;
   logic              temp_vld;
   logic              rdy;
   logic [DATA_W-1:0] dout;
   logic              dout_vld;
   logic              busy;

   modport master (
      output temp_in, temp_vld, rdy,
      input  dout, dout_vld, busy
   );

   modport slave (
      input  temp_in, temp_vld, rdy,
      output dout, dout_vld, busy
   );
endinterface

// File: rtl/temp_uart_fmt.sv
// Formats a 1/16 degC two's-complement sample as an 8-byte ASCII frame "sDDD.T\r\n",
// converting the integer part to BCD serially and pacing bytes on the transmitter's rdy.
module temp_uart_fmt #(
   parameter int DATA_W = 8,
   parameter int TEMP_W = 16
) (
   input logic           clk,
   input logic           rst_n,
   temp_uart_fmt_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StConv, StSend} state_e;

   state_e            state_q, state_d;
   logic [3:0]        cnt_q;
   logic [2:0]        idx_q;
   logic              vld_q;
   logic              sign_q;
   logic [9:0]        bin_q;
   logic [11:0]       bcd_q;
   logic [3:0]        tenth_q;
   logic [DATA_W-1:0] dout_q;

   logic [TEMP_W-1:0] neg_in, mag;
   logic [11:0]       int_part;
   logic [3:0]        frac, tenth_c, tenth_sel;
   logic              sat;
   logic [9:0]        bin_c;
   logic [11:0]       bcd_adj;
   logic [DATA_W-1:0] byte_c;
   logic              send_fire;

   // Magnitude of 0x8000 wraps to 0x8000 itself, which the saturation below also catches.
   assign neg_in    = ~bus.temp_in + TEMP_W'(1);
   assign mag       = bus.temp_in[15] ? neg_in : bus.temp_in;
   assign int_part  = mag[15:4];
   assign frac      = mag[3:0];
   assign tenth_c   = 4'(({4'd0, frac} * 8'd10) >> 4);
   assign sat       = int_part > 12'd999;
   assign bin_c     = sat ? 10'd999 : int_part[9:0];
   assign tenth_sel = sat ? 4'd9 : tenth_c;

   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < 3; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
   end

   always_comb begin
      byte_c = 8'h00;
      unique case (idx_q)
         3'd0: byte_c = sign_q ? 8'h2D : 8'h2B;
         3'd1: byte_c = 8'h30 + {4'd0, bcd_q[11:8]};
         3'd2: byte_c = 8'h30 + {4'd0, bcd_q[7:4]};
         3'd3: byte_c = 8'h30 + {4'd0, bcd_q[3:0]};
         3'd4: byte_c = 8'h2E;
         3'd5: byte_c = 8'h30 + {4'd0, tenth_q};
         3'd6: byte_c = 8'h0D;
         3'd7: byte_c = 8'h0A;
         default: byte_c = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_n) state_q <= StIdle;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (bus.temp_vld) state_d = StConv;
         StConv:  if (cnt_q == 4'd9) state_d = StSend;
         StSend:  if (send_fire && idx_q == 3'd7) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Strobe depends combinationally on rdy so a stalled transmitter never sees a byte.
   always_comb begin
      send_fire    = (state_q == StSend) && bus.rdy && !vld_q;
      bus.dout_vld = send_fire;
      bus.busy     = (state_q != StIdle);
      bus.dout     = send_fire ? byte_c : dout_q;
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         cnt_q   <= '0;
         idx_q   <= '0;
         vld_q   <= 1'b0;
         sign_q  <= 1'b0;
         bin_q   <= '0;
         bcd_q   <= '0;
         tenth_q <= '0;
         dout_q  <= '0;
      end else begin
         vld_q <= send_fire;
         if (state_q == StIdle && bus.temp_vld) begin
            sign_q  <= bus.temp_in[15];
            bin_q   <= bin_c;
            tenth_q <= tenth_sel;
            bcd_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
         end else if (state_q == StConv) begin
            {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
            cnt_q          <= cnt_q + 4'd1;
         end else if (send_fire) begin
            idx_q  <= idx_q + 3'd1;
            dout_q <= byte_c;
         end
      end
   end

endmodule

// File: tb/tb_temp_uart_fmt.sv
// Directed bench for temp_uart_fmt: table of samples with hand-derived ASCII frames,
// plus stall, busy-ignore and mid-frame reset sequences.
module tb_temp_uart_fmt;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   temp_uart_fmt_if bus ();

   temp_uart_fmt #(
      .DATA_W(8),
      .TEMP_W(16)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   typedef struct {
      logic [15:0] temp;
      logic [63:0] exp;
   } vec_t;

   vec_t       vecs [0:9];
   int         checks = 0;
   int         errors = 0;
   logic [7:0] got [$];
   logic [7:0] last_dout;
   logic       have_last = 1'b0;
   logic       prev_vld = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Byte collector and handshake-rule checks, sampled mid-cycle.
   always @(negedge clk) begin
      if (bus.dout_vld === 1'b1) begin
         chk("vld_not_adjacent", {63'd0, prev_vld}, 64'd0);
         chk("vld_only_when_rdy", {63'd0, bus.rdy}, 64'd1);
         got.push_back(bus.dout);
         last_dout = bus.dout;
         have_last = 1'b1;
      end else if (have_last && bus.busy) begin
         chk("dout_stable", {56'd0, bus.dout}, {56'd0, last_dout});
      end
      if (rst_n) have_last = 1'b0;
      prev_vld = bus.dout_vld;
   end

   task automatic wait_bytes(input int n, input int bound);
      for (int k = 0; k < bound && got.size() < n; k++) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic check_frame(input logic [63:0] exp, input string tag);
      chk({tag, "_count"}, 64'(got.size()), 64'd8);
      for (int i = 0; i < 8 && i < got.size(); i++)
         chk($sformatf("%s_byte%0d", tag, i), {56'd0, got[i]}, {56'd0, exp[63-8*i -: 8]});
   endtask

   // Call at #1 after a negedge; temp_vld is sampled on the following rising edge.
   task automatic run_frame(input logic [15:0] t, input logic [63:0] exp, input string tag);
      int lat;
      lat = 0;
      got.delete();
      bus.temp_in  = t;
      bus.temp_vld = 1'b1;
      for (int k = 1; k <= 40 && lat == 0; k++) begin
         @(negedge clk);
         #1;
         if (k == 1) bus.temp_vld = 1'b0;
         if (got.size() != 0) lat = k;
      end
      chk({tag, "_latency"}, 64'(lat), 64'd11);
      wait_bytes(8, 200);
      check_frame(exp, tag);
      repeat (5) @(negedge clk);
      #1;
      chk({tag, "_busy_after"}, {63'd0, bus.busy}, 64'd0);
      chk({tag, "_no_extra"}, 64'(got.size()), 64'd8);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{16'h0191, 64'h2B3032352E300D0A};  // +025.0
      vecs[1] = '{16'hFF5E, 64'h2D3031302E310D0A};  // -010.1
      vecs[2] = '{16'hFC90, 64'h2D3035352E300D0A};  // -055.0
      vecs[3] = '{16'h7FFF, 64'h2B3939392E390D0A};  // saturated
      vecs[4] = '{16'h8000, 64'h2D3939392E390D0A};  // most negative saturates
      vecs[5] = '{16'h0000, 64'h2B3030302E300D0A};
      vecs[6] = '{16'h0058, 64'h2B3030352E350D0A};  // frac 8 -> 5, leading zeros
      vecs[7] = '{16'h3E7F, 64'h2B3939392E390D0A};  // 999 + frac 15, no saturation
      vecs[8] = '{16'h3E80, 64'h2B3939392E390D0A};  // 1000 saturates
      vecs[9] = '{16'hFFFF, 64'h2D3030302E300D0A};  // -1/16 truncates to -000.0

      // Reset with a coincident temp_vld that must be dropped.
      rst_n        = 1'b1;
      bus.rdy      = 1'b1;
      bus.temp_in  = 16'h0191;
      bus.temp_vld = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      rst_n        = 1'b0;
      bus.temp_vld = 1'b0;
      @(negedge clk);
      chk("reset_dout", {56'd0, bus.dout}, 64'd0);
      chk("reset_vld", {63'd0, bus.dout_vld}, 64'd0);
      chk("reset_busy", {63'd0, bus.busy}, 64'd0);
      repeat (20) @(negedge clk);
      chk("reset_vld_ignored", {63'd0, bus.busy}, 64'd0);
      #1;

      for (int v = 0; v < 10; v++) begin
         run_frame(vecs[v].temp, vecs[v].exp, $sformatf("vec%0d", v));
         @(negedge clk);
         #1;
      end

      // Transmitter stalls for 3000 cycles after the second byte.
      got.delete();
      bus.temp_in  = 16'h0191;
      bus.temp_vld = 1'b1;
      @(negedge clk);
      #1;
      bus.temp_vld = 1'b0;
      wait_bytes(2, 100);
      @(posedge clk);
      #1;
      bus.rdy = 1'b0;
      repeat (3000) @(negedge clk);
      chk("stall_count", 64'(got.size()), 64'd2);
      chk("stall_busy", {63'd0, bus.busy}, 64'd1);
      @(posedge clk);
      #1;
      bus.rdy = 1'b1;
      wait_bytes(8, 100);
      check_frame(vecs[0].exp, "stall");

      // A sample offered mid-SEND is ignored; one offered as busy falls is taken.
      repeat (5) @(negedge clk);
      #1;
      got.delete();
      bus.temp_in  = 16'h0191;
      bus.temp_vld = 1'b1;
      @(negedge clk);
      #1;
      bus.temp_vld = 1'b0;
      wait_bytes(3, 100);
      bus.temp_in  = 16'h7FFF;
      bus.temp_vld = 1'b1;
      @(negedge clk);
      #1;
      bus.temp_vld = 1'b0;
      for (int k = 0; k < 100 && bus.busy; k++) begin
         @(negedge clk);
         #1;
      end
      chk("ignore_busy_fell", {63'd0, bus.busy}, 64'd0);
      check_frame(vecs[0].exp, "ignore");
      run_frame(16'hFF5E, vecs[1].exp, "back_to_back");

      // Reset after the fourth byte aborts the frame for good.
      @(negedge clk);
      #1;
      got.delete();
      bus.temp_in  = 16'h0191;
      bus.temp_vld = 1'b1;
      @(negedge clk);
      #1;
      bus.temp_vld = 1'b0;
      wait_bytes(4, 100);
      @(posedge clk);
      #1;
      rst_n        = 1'b1;
      bus.temp_in  = 16'h7FFF;
      bus.temp_vld = 1'b1;
      @(posedge clk);
      #1;
      rst_n        = 1'b0;
      bus.temp_vld = 1'b0;
      @(negedge clk);
      chk("abort_vld", {63'd0, bus.dout_vld}, 64'd0);
      chk("abort_busy", {63'd0, bus.busy}, 64'd0);
      chk("abort_dout", {56'd0, bus.dout}, 64'd0);
      repeat (60) @(negedge clk);
      chk("abort_no_more", 64'(got.size()), 64'd4);
      chk("abort_idle", {63'd0, bus.busy}, 64'd0);
      #1;
      run_frame(16'hFC90, vecs[2].exp, "after_abort");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
